approx_err_monitor: RTL and testbench

- Synthesizable, parametrised error-statistics engine for exact-vs-approximate adder evaluation.
- Consumes paired results (exact sum, approximate sum, plus the operands that produced them) over a programmable window of samples.
- Accumulates error count, sum of absolute error and worst-case error together with its operands, so error metrics are produced on-chip.
- Sits downstream of the exact and approx adder instances in the evaluation harness.

---
 rtl/approx_mon_pkg.sv | 70 +++++++
 rtl/approx_err_stage.sv | 86 ++++++++
 rtl/approx_err_monitor.sv | 193 +++++++++++++++++++
 tb/tb_approx_err_monitor.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mon_pkg.sv
// Shared state encoding and saturating/absolute-difference arithmetic for approx_err_monitor.
// Helpers work at CALC_W bits; callers zero/sign-extend in and truncate out.
package approx_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned CALC_W = 64;

    function automatic logic [CALC_W-1:0] abs_diff(input logic [CALC_W-1:0] a,
                                                   input logic [CALC_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Unsigned add clamped to a WIDTH-bit all-ones ceiling.
    function automatic logic [CALC_W-1:0] sat_add_u(input logic [CALC_W-1:0] acc,
                                                    input logic [CALC_W-1:0] inc,
                                                    input int unsigned       width);
        logic [CALC_W:0] sum;
        logic [CALC_W:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = ({{CALC_W{1'b0}}, 1'b1} << width) - {{CALC_W{1'b0}}, 1'b1};
        return (sum > lim) ? lim[CALC_W-1:0] : sum[CALC_W-1:0];
    endfunction

    function automatic logic sat_ovf_u(input logic [CALC_W-1:0] acc,
                                       input logic [CALC_W-1:0] inc,
                                       input int unsigned       width);
        logic [CALC_W:0] sum;
        logic [CALC_W:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = ({{CALC_W{1'b0}}, 1'b1} << width) - {{CALC_W{1'b0}}, 1'b1};
        return (sum > lim);
    endfunction

    // Signed add clamped to the WIDTH-bit two's-complement range.
    function automatic logic signed [CALC_W-1:0] sat_add_s(input logic signed [CALC_W-1:0] acc,
                                                           input logic signed [CALC_W-1:0] inc,
                                                           input int unsigned              width);
        logic signed [CALC_W:0] sum;
        logic signed [CALC_W:0] hi;
        logic signed [CALC_W:0] lo;
        sum = $signed({acc[CALC_W-1], acc}) + $signed({inc[CALC_W-1], inc});
        hi  = ($signed({{CALC_W{1'b0}}, 1'b1}) <<< (width - 1)) - $signed({{CALC_W{1'b0}}, 1'b1});
        lo  = -hi - $signed({{CALC_W{1'b0}}, 1'b1});
        if (sum > hi) begin
            return hi[CALC_W-1:0];
        end else if (sum < lo) begin
            return lo[CALC_W-1:0];
        end
        return sum[CALC_W-1:0];
    endfunction

    function automatic logic sat_ovf_s(input logic signed [CALC_W-1:0] acc,
                                       input logic signed [CALC_W-1:0] inc,
                                       input int unsigned              width);
        logic signed [CALC_W:0] sum;
        logic signed [CALC_W:0] hi;
        logic signed [CALC_W:0] lo;
        sum = $signed({acc[CALC_W-1], acc}) + $signed({inc[CALC_W-1], inc});
        hi  = ($signed({{CALC_W{1'b0}}, 1'b1}) <<< (width - 1)) - $signed({{CALC_W{1'b0}}, 1'b1});
        lo  = -hi - $signed({{CALC_W{1'b0}}, 1'b1});
        return (sum > hi) || (sum < lo);
    endfunction

endpackage

// File: rtl/approx_err_stage.sv
// Stage-1 register of approx_err_monitor: absolute error, error flag and operands of an accepted sample.
// Optional macro APPROX_MON_BIAS_EN adds the error sign for the bias accumulator.
module approx_err_stage
    import approx_mon_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   s_ex,
    input  logic [WIDTH:0]   s_ap,
    output logic             vld,
    output logic             err,
    output logic [WIDTH:0]   diff,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
`ifdef APPROX_MON_BIAS_EN
    ,
    output logic             ap_gt
`endif
);

    logic             vld_q,  vld_d;
    logic             err_q,  err_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic [WIDTH-1:0] a_q,    a_d;
    logic [WIDTH-1:0] b_q,    b_d;
`ifdef APPROX_MON_BIAS_EN
    logic             ap_gt_q, ap_gt_d;
`endif

    always_comb begin
        vld_d  = load;
        err_d  = err_q;
        diff_d = diff_q;
        a_d    = a_q;
        b_d    = b_q;
`ifdef APPROX_MON_BIAS_EN
        ap_gt_d = ap_gt_q;
`endif
        if (load) begin
            diff_d = (WIDTH+1)'(abs_diff(CALC_W'(s_ex), CALC_W'(s_ap)));
            err_d  = (s_ex != s_ap);
            a_d    = op_a;
            b_d    = op_b;
`ifdef APPROX_MON_BIAS_EN
            ap_gt_d = (s_ap > s_ex);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            diff_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
`ifdef APPROX_MON_BIAS_EN
            ap_gt_q <= 1'b0;
`endif
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            diff_q <= diff_d;
            a_q    <= a_d;
            b_q    <= b_d;
`ifdef APPROX_MON_BIAS_EN
            ap_gt_q <= ap_gt_d;
`endif
        end
    end

    assign vld  = vld_q;
    assign err  = err_q;
    assign diff = diff_q;
    assign a    = a_q;
    assign b    = b_q;
`ifdef APPROX_MON_BIAS_EN
    assign ap_gt = ap_gt_q;
`endif

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error-statistics engine comparing exact and approximate adder sums.
// Optional macro APPROX_MON_BIAS_EN adds the signed saturating bias_sum output.
module approx_err_monitor
    import approx_mon_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   s_ex,
    input  logic [WIDTH:0]   s_ap,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [WIDTH:0]   max_abs_err,
    output logic [WIDTH-1:0] max_op_a,
    output logic [WIDTH-1:0] max_op_b,
    output logic             acc_sat
`ifdef APPROX_MON_BIAS_EN
    ,
    output logic signed [ACC_W-1:0] bias_sum
`endif
);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] len_q,     len_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] sum_q,     sum_d;
    logic [WIDTH:0]   max_q,     max_d;
    logic [WIDTH-1:0] max_a_q,   max_a_d;
    logic [WIDTH-1:0] max_b_q,   max_b_d;
    logic             sat_q,     sat_d;
`ifdef APPROX_MON_BIAS_EN
    logic signed [ACC_W-1:0]  bias_q, bias_d;
    logic signed [CALC_W-1:0] bias_inc;
    logic                     stg_ap_gt;
`endif

    logic             accept;
    logic             clear;
    logic             stg_vld;
    logic             stg_err;
    logic [WIDTH:0]   stg_diff;
    logic [WIDTH-1:0] stg_a;
    logic [WIDTH-1:0] stg_b;

    assign in_ready = (state_q == RUN) && (cnt_q < len_q);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    approx_err_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .op_a  (op_a),
        .op_b  (op_b),
        .s_ex  (s_ex),
        .s_ap  (s_ap),
        .vld   (stg_vld),
        .err   (stg_err),
        .diff  (stg_diff),
        .a     (stg_a),
        .b     (stg_b)
`ifdef APPROX_MON_BIAS_EN
        ,
        .ap_gt (stg_ap_gt)
`endif
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        sum_d     = sum_q;
        max_d     = max_q;
        max_a_d   = max_a_q;
        max_b_d   = max_b_q;
        sat_d     = sat_q;
        clear     = 1'b0;
`ifdef APPROX_MON_BIAS_EN
        bias_d    = bias_q;
        bias_inc  = '0;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d   = win_len;
                    cnt_d   = '0;
                    clear   = 1'b1;
                    state_d = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Final sample is folded into the stats on the edge that empties stage 1.
                if (!stg_vld) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            err_cnt_d = '0;
            sum_d     = '0;
            max_d     = '0;
            max_a_d   = '0;
            max_b_d   = '0;
            sat_d     = 1'b0;
`ifdef APPROX_MON_BIAS_EN
            bias_d    = '0;
`endif
        end else if (stg_vld) begin
            err_cnt_d = err_cnt_q + CNT_W'(stg_err);
            sum_d     = ACC_W'(sat_add_u(CALC_W'(sum_q), CALC_W'(stg_diff), ACC_W));
            sat_d     = sat_q | sat_ovf_u(CALC_W'(sum_q), CALC_W'(stg_diff), ACC_W);
            // Strict compare keeps the earliest sample on ties.
            if (stg_diff > max_q) begin
                max_d   = stg_diff;
                max_a_d = stg_a;
                max_b_d = stg_b;
            end
`ifdef APPROX_MON_BIAS_EN
            bias_inc = stg_ap_gt ? CALC_W'(stg_diff) : -CALC_W'(stg_diff);
            bias_d   = ACC_W'(sat_add_s(CALC_W'(bias_q), bias_inc, ACC_W));
            sat_d    = sat_d | sat_ovf_s(CALC_W'(bias_q), bias_inc, ACC_W);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            max_a_q   <= '0;
            max_b_q   <= '0;
            sat_q     <= 1'b0;
`ifdef APPROX_MON_BIAS_EN
            bias_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            max_a_q   <= max_a_d;
            max_b_q   <= max_b_d;
            sat_q     <= sat_d;
`ifdef APPROX_MON_BIAS_EN
            bias_q    <= bias_d;
`endif
        end
    end

    assign err_count   = err_cnt_q;
    assign sum_abs_err = sum_q;
    assign max_abs_err = max_q;
    assign max_op_a    = max_a_q;
    assign max_op_b    = max_b_q;
    assign acc_sat     = sat_q;
`ifdef APPROX_MON_BIAS_EN
    assign bias_sum    = bias_q;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed and randomized bench for approx_err_monitor; two instances share stimulus (default and 3-bit accumulator).
`timescale 1ns/1ps
module tb_approx_err_monitor;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ACC_W = 24;
    localparam int unsigned ACC_S = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             in_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   s_ex;
    logic [WIDTH:0]   s_ap;

    logic             in_ready, busy, done, acc_sat;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_abs_err;
    logic [WIDTH:0]   max_abs_err;
    logic [WIDTH-1:0] max_op_a, max_op_b;

    logic             in_ready_s, busy_s, done_s, acc_sat_s;
    logic [CNT_W-1:0] err_count_s;
    logic [ACC_S-1:0] sum_abs_err_s;
    logic [WIDTH:0]   max_abs_err_s;
    logic [WIDTH-1:0] max_op_a_s, max_op_b_s;
`ifdef APPROX_MON_BIAS_EN
    logic signed [ACC_W-1:0] bias_sum;
    logic signed [ACC_S-1:0] bias_sum_s;
`endif

    int checks = 0;
    int errors = 0;
    int qa[$], qb[$], qex[$], qap[$];

    always #5 clk = ~clk;

    approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .s_ex(s_ex), .s_ap(s_ap), .busy(busy), .done(done),
        .err_count(err_count), .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
        .max_op_a(max_op_a), .max_op_b(max_op_b), .acc_sat(acc_sat)
`ifdef APPROX_MON_BIAS_EN
        , .bias_sum(bias_sum)
`endif
    );

    approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_s (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_ready(in_ready_s), .op_a(op_a), .op_b(op_b),
        .s_ex(s_ex), .s_ap(s_ap), .busy(busy_s), .done(done_s),
        .err_count(err_count_s), .sum_abs_err(sum_abs_err_s), .max_abs_err(max_abs_err_s),
        .max_op_a(max_op_a_s), .max_op_b(max_op_b_s), .acc_sat(acc_sat_s)
`ifdef APPROX_MON_BIAS_EN
        , .bias_sum(bias_sum_s)
`endif
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference statistics of the samples currently in the window, for an accumulator of w bits.
    task automatic model(input int w, output longint cnt, output longint sum, output longint mx,
                         output longint ma, output longint mb, output longint sat, output longint bias);
        longint hi, bhi, blo, d, ad;
        cnt = 0; sum = 0; mx = 0; ma = 0; mb = 0; sat = 0; bias = 0;
        hi  = (longint'(1) << w) - 1;
        bhi = (longint'(1) << (w - 1)) - 1;
        blo = -bhi - 1;
        for (int i = 0; i < qex.size(); i++) begin
            d  = longint'(qap[i]) - longint'(qex[i]);
            ad = (d < 0) ? -d : d;
            if (ad != 0) cnt++;
            sum += ad;
            if (sum > hi) begin sum = hi; sat = 1; end
            if (ad > mx) begin mx = ad; ma = qa[i]; mb = qb[i]; end
            bias += d;
            if (bias > bhi) begin bias = bhi; end
            if (bias < blo) begin bias = blo; end
`ifdef APPROX_MON_BIAS_EN
            if (bias == bhi || bias == blo) begin
                if (bias - d + d != bias || (bias - (bias - d)) != d) sat = 1;
            end
`endif
        end
    endtask

    // Recompute with explicit overflow tracking for the bias path.
    task automatic model_bias_sat(input int w, output longint bsat);
        longint bhi, blo, b;
        bsat = 0; b = 0;
        bhi = (longint'(1) << (w - 1)) - 1;
        blo = -bhi - 1;
        for (int i = 0; i < qex.size(); i++) begin
            b += longint'(qap[i]) - longint'(qex[i]);
            if (b > bhi) begin b = bhi; bsat = 1; end
            if (b < blo) begin b = blo; bsat = 1; end
        end
    endtask

    task automatic check_stats(input string tag);
        longint c, s, m, a, b, t, bi, bs;
        model(ACC_W, c, s, m, a, b, t, bi);
`ifdef APPROX_MON_BIAS_EN
        model_bias_sat(ACC_W, bs);
        t = t | bs;
        chk({tag, ".bias"}, longint'(bias_sum), bi);
`endif
        chk({tag, ".err_count"}, longint'(err_count), c);
        chk({tag, ".sum_abs"}, longint'(sum_abs_err), s);
        chk({tag, ".max_abs"}, longint'(max_abs_err), m);
        chk({tag, ".max_a"}, longint'(max_op_a), a);
        chk({tag, ".max_b"}, longint'(max_op_b), b);
        chk({tag, ".acc_sat"}, longint'(acc_sat), t);
        model(ACC_S, c, s, m, a, b, t, bi);
`ifdef APPROX_MON_BIAS_EN
        model_bias_sat(ACC_S, bs);
        t = t | bs;
        chk({tag, ".s.bias"}, longint'(bias_sum_s), bi);
`endif
        chk({tag, ".s.err_count"}, longint'(err_count_s), c);
        chk({tag, ".s.sum_abs"}, longint'(sum_abs_err_s), s);
        chk({tag, ".s.acc_sat"}, longint'(acc_sat_s), t);
    endtask

    // All tasks begin and end 1 ns after a rising edge.
    task automatic start_win(input int len);
        start   = 1'b1;
        win_len = CNT_W'(len);
        qa.delete(); qb.delete(); qex.delete(); qap.delete();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int ex, input int ap);
        int guard = 0;
        in_valid = 1'b1;
        op_a = WIDTH'(a); op_b = WIDTH'(b);
        s_ex = (WIDTH+1)'(ex); s_ap = (WIDTH+1)'(ap);
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("send_timeout", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        qa.push_back(a); qb.push_back(b); qex.push_back(ex); qap.push_back(ap);
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (!done && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, ".done"}, longint'(done), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; win_len = '0; in_valid = 1'b0;
        op_a = '0; op_b = '0; s_ex = '0; s_ap = '0;
        idle(2);
        chk("rst.in_ready", longint'(in_ready), 0);
        chk("rst.busy", longint'(busy), 0);
        chk("rst.done", longint'(done), 0);
        chk("rst.err_count", longint'(err_count), 0);
        rst = 1'b0;
        idle(1);

        // Basic window of three back-to-back samples.
        start_win(3);
        chk("s1.busy", longint'(busy), 1);
        chk("s1.in_ready", longint'(in_ready), 1);
        send(2, 3, 5, 5);
        send(4, 5, 9, 8);
        send(6, 6, 12, 15);
        chk("s1.ready_after", longint'(in_ready), 0);
        chk("s1.done_e0", longint'(done), 0);
        idle(1);
        chk("s1.done_e1", longint'(done), 0);
        idle(1);
        chk("s1.done_e2", longint'(done), 1);
        chk("s1.cnt_const", longint'(err_count), 2);
        chk("s1.sum_const", longint'(sum_abs_err), 4);
        chk("s1.max_const", longint'(max_abs_err), 3);
        chk("s1.max_a_const", longint'(max_op_a), 6);
        chk("s1.max_b_const", longint'(max_op_b), 6);
`ifdef APPROX_MON_BIAS_EN
        chk("s1.bias_const", longint'(bias_sum), 2);
`endif
        check_stats("s1");
        idle(3);
        chk("s1.hold_done", longint'(done), 1);
        chk("s1.hold_cnt", longint'(err_count), 2);

        // Tie on the worst-case error keeps the first sample.
        start_win(2);
        send(1, 1, 2, 4);
        send(7, 7, 14, 12);
        wait_done("tie");
        chk("tie.max_a", longint'(max_op_a), 1);
        chk("tie.max_b", longint'(max_op_b), 1);
        check_stats("tie");

        // Accumulator saturation on the 3-bit instance.
        start_win(3);
        send(1, 3, 4, 0);
        send(2, 2, 4, 0);
        send(0, 4, 4, 0);
        wait_done("sat");
        chk("sat.s.sum", longint'(sum_abs_err_s), 7);
        chk("sat.s.acc_sat", longint'(acc_sat_s), 1);
        chk("sat.s.err_count", longint'(err_count_s), 3);
        chk("sat.sum", longint'(sum_abs_err), 12);
        check_stats("sat");

        // Zero-length window goes straight to DONE with cleared stats.
        start_win(0);
        chk("zero.done", longint'(done), 1);
        chk("zero.busy", longint'(busy), 0);
        chk("zero.err_count", longint'(err_count), 0);
        chk("zero.sum", longint'(sum_abs_err), 0);
        chk("zero.max", longint'(max_abs_err), 0);
        chk("zero.s.acc_sat", longint'(acc_sat_s), 0);

        // start during RUN must not change the latched length.
        start_win(3);
        send(3, 3, 6, 7);
        start = 1'b1; win_len = CNT_W'(5);
        idle(1);
        start = 1'b0;
        chk("ign.busy", longint'(busy), 1);
        send(5, 1, 6, 2);
        send(2, 9, 11, 11);
        chk("ign.ready_after3", longint'(in_ready), 0);
        wait_done("ign");
        check_stats("ign");

        // Mid-window reset discards partial statistics.
        start_win(4);
        send(4, 4, 8, 1);
        send(3, 2, 5, 9);
        idle(1);
        rst = 1'b1;
        idle(1);
        chk("mrst.in_ready", longint'(in_ready), 0);
        chk("mrst.busy", longint'(busy), 0);
        chk("mrst.done", longint'(done), 0);
        chk("mrst.err_count", longint'(err_count), 0);
        chk("mrst.sum", longint'(sum_abs_err), 0);
        chk("mrst.max", longint'(max_abs_err), 0);
        chk("mrst.max_a", longint'(max_op_a), 0);
        rst = 1'b0;
        in_valid = 1'b1;
        idle(2);
        chk("idle.in_ready", longint'(in_ready), 0);
        in_valid = 1'b0;

        // Randomized windows with random idle gaps.
        for (int w = 0; w < 6; w++) begin
            int len;
            len = int'($urandom_range(1, 8));
            start_win(len);
            for (int k = 0; k < len; k++) begin
                int a, b;
                idle(int'($urandom_range(0, 2)));
                a = int'($urandom_range(0, 15));
                b = int'($urandom_range(0, 15));
                send(a, b, a + b, int'($urandom_range(0, 31)));
            end
            wait_done("rnd");
            check_stats("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
